// File: rtl/digital_resonator_bank.sv
// digital_resonator_bank: time-multiplexed bank of NUM_CH two-pole IIR resonators
// sharing a single multiplier. Each channel computes y = g*x + a1*y1 - a2*y2.
// Optional build macro RESONATOR_SAT_EN: saturate results and report clipping;
// without it results wrap to DATA_W bits and sat_flag stays 0.
module digital_resonator_bank #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned COEF_FRAC = 16,
  parameter int unsigned NUM_CH    = 4,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clr,
  input  logic [NUM_CH*DATA_W-1:0] d,
  input  logic                     coef_we,
  input  logic [CH_W-1:0]          coef_ch,
  input  logic [1:0]               coef_sel,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [NUM_CH*DATA_W-1:0] q,
  output logic                     q_valid,
  output logic                     busy,
  output logic                     sat_flag,
  output logic                     overrun
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + 2;
  localparam logic signed [COEF_W-1:0] G_ONE = COEF_W'(64'(1) << COEF_FRAC);

  typedef enum logic [2:0] {
    S_IDLE, S_MAC_G, S_MAC_A1, S_MAC_A2, S_STORE, S_DONE
  } state_t;

  state_t state, state_next;

  logic signed [COEF_W-1:0] g_sh   [NUM_CH];
  logic signed [COEF_W-1:0] a1_sh  [NUM_CH];
  logic signed [COEF_W-1:0] a2_sh  [NUM_CH];
  logic signed [COEF_W-1:0] g_act  [NUM_CH];
  logic signed [COEF_W-1:0] a1_act [NUM_CH];
  logic signed [COEF_W-1:0] a2_act [NUM_CH];
  logic signed [DATA_W-1:0] x_lat  [NUM_CH];
  logic signed [DATA_W-1:0] y1     [NUM_CH];
  logic signed [DATA_W-1:0] y2     [NUM_CH];
  logic signed [DATA_W-1:0] stage  [NUM_CH];

  logic [CH_W-1:0]          ch;
  logic                     last_ch;
  logic                     accept;
  logic signed [DATA_W-1:0] mul_x;
  logic signed [COEF_W-1:0] mul_c;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] res;
  logic                     clip;
  logic                     sat_acc;

  assign last_ch = (ch == CH_W'(NUM_CH - 1));
  assign accept  = (state == S_IDLE) && enable && !clr;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; clr aborts any frame
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (enable) state_next = S_MAC_G;
        S_MAC_G:  state_next = S_MAC_A1;
        S_MAC_A1: state_next = S_MAC_A2;
        S_MAC_A2: state_next = S_STORE;
        S_STORE:  state_next = last_ch ? S_DONE : S_MAC_G;
        S_DONE:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Shared multiplier operand select
  always_comb begin
    mul_x = x_lat[ch];
    mul_c = g_act[ch];
    case (state)
      S_MAC_A1: begin mul_x = y1[ch]; mul_c = a1_act[ch]; end
      S_MAC_A2: begin mul_x = y2[ch]; mul_c = a2_act[ch]; end
      default:  ;
    endcase
  end

  assign prod = PROD_W'(mul_x) * PROD_W'(mul_c);

  // Rescale accumulator to sample width (floor shift, then clip or wrap)
`ifdef RESONATOR_SAT_EN
  logic signed [ACC_W-1:0] shifted;
  always_comb begin
    shifted = acc >>> COEF_FRAC;
    res     = shifted[DATA_W-1:0];
    clip    = 1'b0;
    if (!(&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1])) begin
      clip = 1'b1;
      res  = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                              : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    res  = DATA_W'(acc >>> COEF_FRAC);
    clip = 1'b0;
  end
`endif

  // Shadow coefficient registers, written from the host port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        g_sh[k]  <= G_ONE;
        a1_sh[k] <= '0;
        a2_sh[k] <= '0;
      end
    end else if (coef_we) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (coef_ch == CH_W'(k)) begin
          case (coef_sel)
            2'd0:    g_sh[k]  <= coef_data;
            2'd1:    a1_sh[k] <= coef_data;
            2'd2:    a2_sh[k] <= coef_data;
            default: ;
          endcase
        end
      end
    end
  end

  // Active coefficients snapshot the shadow set at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        g_act[k]  <= G_ONE;
        a1_act[k] <= '0;
        a2_act[k] <= '0;
      end
    end else if (accept) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        g_act[k]  <= g_sh[k];
        a1_act[k] <= a1_sh[k];
        a2_act[k] <= a2_sh[k];
      end
    end
  end

  // Datapath, filter state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        x_lat[k] <= '0;
        y1[k]    <= '0;
        y2[k]    <= '0;
        stage[k] <= '0;
      end
      ch       <= '0;
      acc      <= '0;
      sat_acc  <= 1'b0;
      q        <= '0;
      q_valid  <= 1'b0;
      busy     <= 1'b0;
      sat_flag <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      busy    <= (state_next != S_IDLE);
      if (clr) begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          y1[k] <= '0;
          y2[k] <= '0;
        end
        ch      <= '0;
        overrun <= 1'b0;
      end else begin
        if (enable && (state != S_IDLE)) overrun <= 1'b1;
        case (state)
          S_IDLE: begin
            if (enable) begin
              for (int unsigned k = 0; k < NUM_CH; k++)
                x_lat[k] <= d[k*DATA_W +: DATA_W];
              ch      <= '0;
              sat_acc <= 1'b0;
            end
          end
          S_MAC_G:  acc <= ACC_W'(prod);
          S_MAC_A1: acc <= acc + ACC_W'(prod);
          S_MAC_A2: acc <= acc - ACC_W'(prod);
          S_STORE: begin
            y2[ch]    <= y1[ch];
            y1[ch]    <= res;
            stage[ch] <= res;
            sat_acc   <= sat_acc | clip;
            if (!last_ch) ch <= ch + CH_W'(1);
          end
          S_DONE: begin
            for (int unsigned k = 0; k < NUM_CH; k++)
              q[k*DATA_W +: DATA_W] <= stage[k];
            q_valid  <= 1'b1;
            sat_flag <= sat_acc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digital_resonator_bank.sv
// Scoreboard bench for digital_resonator_bank (default parameters, 4 channels).
module tb_digital_resonator_bank;

  logic        tb_local_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] d = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_ch = '0;
  logic [1:0]  coef_sel = '0;
  logic [17:0] coef_data = '0;
  logic [63:0] q;
  logic        q_valid;
  logic        busy;
  logic        sat_flag;
  logic        overrun;

  digital_resonator_bank dut (
    .clk(tb_local_clock), .reset_n(reset_n), .enable(enable), .clr(clr), .d(d),
    .coef_we(coef_we), .coef_ch(coef_ch), .coef_sel(coef_sel), .coef_data(coef_data),
    .q(q), .q_valid(q_valid), .busy(busy), .sat_flag(sat_flag), .overrun(overrun)
  );

  always #5 tb_local_clock = ~tb_local_clock;

  typedef struct {
    logic [63:0] qv;
    logic        sat;
    int          issue;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          qv_count = 0;
  int          n_pushed = 0;
  logic [63:0] last_q = '0;

  always @(posedge tb_local_clock) cyc <= cyc + 1;

  function automatic logic [63:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every q_valid pulse
  always @(negedge tb_local_clock) begin
    if (reset_n && q_valid) begin
      exp_t e;
      qv_count++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_q_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("q", q, e.qv);
        check("sat_flag", 64'(sat_flag), 64'(e.sat));
        check("latency", 64'(cyc - e.issue), 64'd17);
        last_q = e.qv;
      end
    end
  end

  task automatic write_coef(input int ch, input int sel, input int val);
    @(negedge tb_local_clock);
    coef_we = 1'b1; coef_ch = 2'(ch); coef_sel = 2'(sel); coef_data = 18'(val);
    @(negedge tb_local_clock);
    coef_we = 1'b0;
  endtask

  // Call just after a negedge: drives one enable and optionally records the expectation
  task automatic start_frame(input logic [63:0] dv, input logic [63:0] ev, input logic es,
                             input bit push);
    exp_t e;
    d = dv;
    enable = 1'b1;
    if (push) begin
      e.qv = ev; e.sat = es; e.issue = cyc + 1;
      sb.push_back(e);
      n_pushed++;
    end
    @(negedge tb_local_clock);
    enable = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge tb_local_clock);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got busy=1 after %0d cycles expected 0", n);
    end
  endtask

  task automatic frame(input logic [63:0] dv, input logic [63:0] ev, input logic es);
    @(negedge tb_local_clock);
    start_frame(dv, ev, es, 1'b1);
    wait_idle();
  endtask

  task automatic pulse_clr();
    @(negedge tb_local_clock);
    clr = 1'b1;
    @(negedge tb_local_clock);
    clr = 1'b0;
  endtask

  initial begin
    logic        exp_sat;
    logic [63:0] sat_q;

    repeat (3) @(negedge tb_local_clock);
    check("reset_q", q, 64'd0);
    check("reset_q_valid", 64'(q_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_sat_flag", 64'(sat_flag), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;

    // Passthrough after reset
    frame(pack4(1234, -500, 0, 32767), pack4(1234, -500, 0, 32767), 1'b0);

    // Resonator impulse on channel 1; sel 3 write must be ignored
    pulse_clr();
    write_coef(1, 0, 65536);
    write_coef(1, 1, 65536);
    write_coef(1, 2, 32768);
    write_coef(0, 3, 0);
    frame(pack4(10, 1000, -3, 7), pack4(10, 1000, -3, 7), 1'b0);
    frame(pack4(20, 0, -3, 7),    pack4(20, 1000, -3, 7), 1'b0);
    frame(pack4(30, 0, -3, 7),    pack4(30, 500, -3, 7), 1'b0);
    frame(pack4(40, 0, -3, 7),    pack4(40, 0, -3, 7), 1'b0);
    frame(pack4(50, 0, -3, 7),    pack4(50, -250, -3, 7), 1'b0);

    // Saturation / wrap on channel 0 with g = 1.5
    pulse_clr();
    write_coef(0, 0, 98304);
`ifdef RESONATOR_SAT_EN
    exp_sat = 1'b1;
    sat_q   = pack4(32767, 0, 0, 0);
`else
    exp_sat = 1'b0;
    sat_q   = pack4(-16386, 0, 0, 0);
`endif
    frame(pack4(32767, 0, 0, 0), sat_q, exp_sat);
    write_coef(0, 0, 65536);

    // Overrun: second enable three cycles into the frame is dropped
    @(negedge tb_local_clock);
    start_frame(pack4(5, 0, 6, -8), pack4(5, 0, 6, -8), 1'b0, 1'b1);
    repeat (2) @(negedge tb_local_clock);
    enable = 1'b1;
    @(negedge tb_local_clock);
    enable = 1'b0;
    check("overrun_rise", 64'(overrun), 64'd1);
    wait_idle();
    repeat (5) @(negedge tb_local_clock);
    check("overrun_single_valid", 64'(qv_count), 64'(n_pushed));
    pulse_clr();
    check("overrun_cleared", 64'(overrun), 64'd0);

    // clr and enable together: enable dropped, no overrun
    @(negedge tb_local_clock);
    clr = 1'b1; enable = 1'b1;
    @(negedge tb_local_clock);
    clr = 1'b0; enable = 1'b0;
    check("clr_enable_busy", 64'(busy), 64'd0);
    check("clr_enable_overrun", 64'(overrun), 64'd0);

    // clr mid-frame aborts without q_valid and leaves q untouched
    @(negedge tb_local_clock);
    start_frame(pack4(999, 999, 999, 999), 64'd0, 1'b0, 1'b0);
    repeat (4) @(negedge tb_local_clock);
    clr = 1'b1;
    @(negedge tb_local_clock);
    clr = 1'b0;
    check("clr_abort_busy", 64'(busy), 64'd0);
    check("clr_abort_q", q, last_q);
    repeat (25) @(negedge tb_local_clock);
    check("clr_abort_no_valid", 64'(qv_count), 64'(n_pushed));
    frame(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 1'b0);

    // Shadowing: ch3 write coincides with the accepted enable, ch2 write lands mid-frame
    @(negedge tb_local_clock);
    coef_we = 1'b1; coef_ch = 2'd3; coef_sel = 2'd0; coef_data = 18'd0;
    start_frame(pack4(0, 0, 400, 77), pack4(0, 0, 400, 77), 1'b0, 1'b1);
    coef_we = 1'b0;
    write_coef(2, 0, 0);
    wait_idle();
    frame(pack4(0, 0, 400, 77), pack4(0, 0, 0, 0), 1'b0);

    // Asynchronous reset mid-frame, then coefficients back to passthrough
    @(negedge tb_local_clock);
    start_frame(pack4(1, 2, 3, 4), 64'd0, 1'b0, 1'b0);
    repeat (4) @(negedge tb_local_clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_q", q, 64'd0);
    @(negedge tb_local_clock);
    reset_n = 1'b1;
    frame(pack4(11, 22, 33, 44), pack4(11, 22, 33, 44), 1'b0);

    repeat (5) @(negedge tb_local_clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("valid_count", 64'(qv_count), 64'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/digital_resonator_bank.md
# digital_resonator_bank

Parametrised, time-multiplexed bank of NUM_CH independent two-pole IIR resonators that share one multiplier. Each channel computes y[n] = g·x[n] + a1·y[n-1] − a2·y[n-2]. A sample-rate `enable` strobe (the system-clock-derived time base, e.g. 50 MHz / 5 kHz) drives one frame per strobe. Coefficients are programmable at runtime per channel, and the block sits between the sample source and downstream audio/DSP logic.

## Interface
- DATA_W, 16, signed sample width (input, output, state)
- COEF_W, 18, signed coefficient width
- COEF_FRAC, 16, coefficient fractional bits (default Q2.16, range [−2, 2))
- NUM_CH, 4, channel count, ≥1; CH_W = max(1, $clog2(NUM_CH))
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  one-cycle sample strobe; starts a frame
- clr  in  1  synchronous clear of filter state and overrun
- d  in  NUM_CH*DATA_W  signed inputs; channel k at [k*DATA_W +: DATA_W]
- coef_we  in  1  coefficient write strobe
- coef_ch  in  CH_W  target channel
- coef_sel  in  2  0 = g, 1 = a1, 2 = a2, 3 = ignored
- coef_data  in  COEF_W  signed coefficient value
- q  out  NUM_CH*DATA_W  signed outputs, same packing as d
- q_valid  out  1  one-cycle pulse when q updates
- busy  out  1  frame in progress
- sat_flag  out  1  valid with q_valid: any channel clipped this frame
- overrun  out  1  sticky: enable arrived while busy

## Operation
- Reset values:
  - q = 0, q_valid = 0, busy = 0, sat_flag = 0, overrun = 0.
  - All y1/y2 = 0.
  - Shadow and active coefficients: g = 2^COEF_FRAC (1.0), a1 = 0, a2 = 0. The block is a passthrough after reset.
- Coefficient writes:
  - A write with coef_we = 1 updates the shadow register on the next edge.
  - The write is ignored if coef_ch ≥ NUM_CH or coef_sel = 3.
  - The shadow set is copied to the active set on the edge that accepts `enable`, so coefficients never change mid-frame.
  - A write coinciding with an accepted enable is not part of that frame's copy.
- FSM: IDLE → MAC_G → MAC_A1 → MAC_A2 → STORE. STORE moves to MAC_G of the next channel, or to DONE after channel NUM_CH−1. DONE returns to IDLE.
  - IDLE: when enable = 1, latch all d, copy coefficients, set ch = 0, go to MAC_G. busy = 1 in every state except IDLE.
  - MAC_G: acc = g·x.
  - MAC_A1: acc += a1·y1.
  - MAC_A2: acc −= a2·y2.
  - STORE: r = acc >>> COEF_FRAC (arithmetic shift, floor), then resized to DATA_W. Then y2 ← y1, y1 ← r, q[ch] staging ← r.
  - DONE: q ← staging, q_valid = 1, sat_flag = OR of per-channel clip flags.
- Arithmetic:
  - Products are full precision, DATA_W + COEF_W bits.
  - The accumulator is DATA_W + COEF_W + 2 bits and does not overflow.
- Boundaries:
  - enable while busy: dropped; overrun set (sticky).
  - clr:
    - Highest priority.
    - Zeroes all y1/y2 and overrun.
    - Aborts any frame and returns to IDLE. No q_valid; q holds its prior value.
    - clr and enable on the same cycle: clr wins and the enable is dropped without setting overrun.
  - Asynchronous reset mid-frame: all state returns to reset values immediately.
  - NUM_CH = 1: coef_ch is 1 bit, and only value 0 is accepted.

## Timing
- enable is sampled at edge E0.
- Each channel takes 4 cycles (MAC_G, MAC_A1, MAC_A2, STORE).
- DONE is at edge E0 + 4·NUM_CH + 1. q and sat_flag update, and q_valid is high for the following cycle (default: 17 edges).
- busy is high from E0 through the DONE cycle. The next enable is accepted from the first IDLE cycle, a minimum spacing of 4·NUM_CH + 2 cycles.
- overrun rises the cycle after the offending enable.

## Configuration
- RESONATOR_SAT_EN:
  - Defined: the STORE result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1], and the clip sets that channel's flag.
  - Undefined: the result is truncated to the low DATA_W bits (two's-complement wrap), and sat_flag is tied to 0.

## Test plan
- Reset passthrough: release reset, d[ch0] = 1234, one enable → q_valid 17 cycles later, q[ch0] = 1234, sat_flag = 0.
- Resonator impulse:
  - Setup: ch1 g = 65536, a1 = 65536, a2 = 32768.
  - Stimulus: x = 1000 then zeros over 5 frames.
  - Required: q[ch1] = 1000, 1000, 500, 0, −250. Other channels are unaffected.
- Saturation:
  - Setup: ch0 g = 98304 (1.5), x = 32767.
  - With RESONATOR_SAT_EN: q = 32767, sat_flag = 1.
  - Without it: q = −16386, sat_flag = 0.
- Overrun: a second enable 3 cycles after the first → second dropped, overrun = 1, exactly one q_valid. A later clr → overrun = 0.
- clr mid-frame: clr at cycle 6 of a frame → no q_valid, busy = 0 next cycle, q unchanged. The next frame with x = 0 yields q = 0.
- Coefficient shadowing: write ch2 g = 0 while busy → the current frame uses the old g. The next frame gives q[ch2] = 0 (with y1 = y2 = 0 state).
